// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad scan types, column drive patterns and row decode helpers
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } scan_state_e;

    // Active-low walking-zero drive, same pattern as the display anodes
    localparam logic [3:0] COL_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic single_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous active-low row lines, resets to all ones
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign q_out = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with debounce and sticky valid/ack key output
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [3:0]       row_in,
    input  logic             key_ack,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             overrun
);

    localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_N    = 4'(DEBOUNCE_SCANS);

    logic [3:0]       w_rows_s;
    logic             w_tick;
    logic             w_single;
    logic [1:0]       w_row_idx;
    scan_state_e      w_state_nxt;
    logic [1:0]       w_col_nxt;
    logic [3:0]       w_match_nxt;
    logic [3:0]       w_rel_nxt;
    logic             w_capture;
    logic             w_emit;

    scan_state_e      r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_col_out;
    logic [3:0]       r_cap_rows;
    logic [1:0]       r_cap_row;
    logic [3:0]       r_match;
    logic [3:0]       r_rel;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

    sync2 #(.W(4)) u_row_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d_in   (row_in),
        .q_out  (w_rows_s)
    );

    assign w_tick    = (r_div == DIV_LAST);
    assign w_single  = single_low(w_rows_s);
    assign w_row_idx = low_index(w_rows_s);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rows are only judged at the end of a column period so the lines have settled
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_match_nxt = r_match;
        w_rel_nxt   = r_rel;
        w_capture   = 1'b0;
        w_emit      = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_single) begin
                        w_capture   = 1'b1;
                        w_match_nxt = 4'd1;
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_rows_s == r_cap_rows) begin
                        w_match_nxt = r_match + 4'd1;
                        if (w_match_nxt == DEB_N) begin
                            w_emit      = 1'b1;
                            w_rel_nxt   = 4'd0;
                            w_state_nxt = RELEASE;
                        end
                    end else begin
                        w_col_nxt   = r_col + 2'd1;
                        w_state_nxt = SCAN;
                    end
                end
                RELEASE: begin
                    if (w_rows_s == 4'hF) begin
                        w_rel_nxt = r_rel + 4'd1;
                        if (w_rel_nxt == DEB_N) begin
                            w_rel_nxt   = 4'd0;
                            w_col_nxt   = r_col + 2'd1;
                            w_state_nxt = SCAN;
                        end
                    end else begin
                        w_rel_nxt = 4'd0;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_div       <= '0;
            r_col       <= 2'd0;
            r_col_out   <= 4'b0111;
            r_cap_rows  <= 4'hF;
            r_cap_row   <= 2'd0;
            r_match     <= 4'd0;
            r_rel       <= 4'd0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
            r_col     <= w_col_nxt;
            r_col_out <= COL_PATTERN[w_col_nxt];
            r_match   <= w_match_nxt;
            r_rel     <= w_rel_nxt;
            if (w_capture) begin
                r_cap_rows <= w_rows_s;
                r_cap_row  <= w_row_idx;
            end
            // An ack in the emit cycle frees the slot, so the new key replaces the old one
            if (w_emit) begin
                if (!r_key_valid || key_ack) begin
                    r_key_code  <= {r_cap_row, r_col};
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (key_ack && r_key_valid) begin
                r_key_valid <= 1'b0;
                r_overrun   <= 1'b0;
            end
        end
    end

    assign col_out   = r_col_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad for the calculator front end: drives one column low at a time and reads the four row lines back. It debounces a single pressed key and presents its 4-bit code to the calculator control logic through a sticky valid/ack handshake. The column drive uses the same active-low walking-zero pattern as the display anode drive, so the keypad is the input-side counterpart of the multiplexed display.

## Interface
- SCAN_DIV, 100000: clock cycles per column period; 1 ms at 100 MHz; must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive matching samples required for press or release; range 2..15.
- clk_in  input  1  system clock.
- rst  input  1  reset; asynchronous and active-high.
- row_in  input  4  keypad rows; active-low, externally pulled up, asynchronous.
- key_ack  input  1  consumer acknowledge; single-cycle pulse.
- col_out  output  4  column drive, active-low one-cold: col0=0111, col1=1011, col2=1101, col3=1110.
- key_code  output  4  row*4 + col of the last accepted key.
- key_valid  output  1  key_code holds an unconsumed key.
- overrun  output  1  sticky: a key was dropped while key_valid was high.

## Operation
- row_in passes through a 2-flop synchronizer; all logic uses the synchronized value rows_s.
- The divider counts 0..SCAN_DIV-1 continuously; tick = (divider == SCAN_DIV-1).
- Rows are evaluated only on tick, at the end of a column period, for settling.
- State SCAN:
  - On tick, if rows_s has exactly one bit low: capture the row index and the current column, set match=1, go to DEBOUNCE. The column is frozen.
  - On tick, if rows_s is all high or has ≥2 bits low (ghosting): advance the column (3 wraps to 0) and stay in SCAN.
- State DEBOUNCE (column frozen):
  - On tick with rows_s equal to the captured pattern: match++.
  - When match reaches DEBOUNCE_SCANS, emit the key and go to RELEASE.
  - On tick with any other pattern: advance the column and return to SCAN.
- State RELEASE (column frozen):
  - On tick with rows_s all high: rel++. Any low row resets rel to 0.
  - When rel reaches DEBOUNCE_SCANS, advance the column and go to SCAN.
  - Holding a key therefore produces exactly one emit.
- Emit:
  - If key_valid=0, or key_ack=1 in the same cycle: key_code <= row*4+col and key_valid <= 1.
  - Otherwise the key is dropped and overrun <= 1.
- key_ack with key_valid=1 and no emit: key_valid <= 0 and overrun <= 0.
- key_ack with key_valid=0: no effect.
- Reset, asynchronous and effective mid-operation:
  - col_out = 0111, key_code = 0, key_valid = 0, overrun = 0.
  - State = SCAN; divider, column, match and rel = 0; synchronizer flops = 1111.

## Timing
- col_out changes the cycle after the tick that advances the column; the first column period after reset is a full SCAN_DIV cycles.
- Row-to-rows_s latency is 2 cycles; a row change later than SCAN_DIV-3 cycles into a period is seen one period late.
- Press latency: key_valid rises 1 cycle after the tick at which match reaches DEBOUNCE_SCANS, i.e. (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles after the capturing tick.
- key_valid falls the cycle after key_ack.
- Emit coincident with ack: key_valid stays 1, key_code updates, no overrun.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package keypad_pkg:
  - state encoding SCAN=0, DEBOUNCE=1, RELEASE=2.
  - COL_PATTERN[0..3] constants (0111, 1011, 1101, 1110), shared with the anode drive.
  - KEY_W=4.
- One sub-module, sync2 (4-bit two-flop synchronizer with async reset to 1s). The rest is a single module.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset mid-DEBOUNCE:
  - Stimulus: assert rst while a key is being debounced.
  - Response: the same cycle shows col_out=0111, key_valid=0, overrun=0; after release, scanning restarts at col0 with divider 0.
- Single press:
  - Stimulus: row 2 held low while col1 is driven, for ≥4 periods.
  - Response: key_code=9 and key_valid=1 exactly 9 cycles after the capturing tick; col_out is frozen at 1011 until 3 all-high ticks after release.
- Bounce:
  - Stimulus: row0 low on col3 for one tick, then high.
  - Response: no emit; the column advances to col0 (0111) and scanning continues.
- Ghosting:
  - Stimulus: rows 0 and 1 low together on col2.
  - Response: no capture; the column keeps rotating.
- Overrun and ack:
  - Stimulus: press key 5 and do not ack, then press key 15; then pulse key_ack.
  - Response: key_code stays 5 and overrun=1; after the ack, key_valid=0 and overrun=0.
- Held key and ack coincident with emit:
  - Stimulus: hold key 0 for 20 periods; separately, pulse key_ack on the emit cycle.
  - Response: a single emit for the held key; with the coincident ack, key_valid stays 1, key_code shows the new key, and overrun=0.
